// File: rtl/bus_arbiter.sv
// ============================================================================
// Module   : bus_arbiter
// Brief    : Two-master, three-slave round-robin serial bus arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m1_req,
    input  logic       m1_addr,
    input  logic       m1_addr_valid,
    input  logic       m2_req,
    input  logic       m2_addr,
    input  logic       m2_addr_valid,
    output logic [1:0] bus_grant,
    output logic [2:0] slave_grant,
    output logic       m1_ack,
    output logic       m2_ack,
    output logic       addr_err,
    output logic       timeout
);

    typedef enum logic [2:0] {
        c_IDLE    = 3'd0,
        c_GRANT   = 3'd1,
        c_ADDR    = 3'd2,
        c_CONNECT = 3'd3,
        c_RELEASE = 3'd4
    } state_t;

    localparam logic [TO_W-1:0] c_TIMEOUT = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] c_CNT_MAX = '1;

    state_t          r_state_q, w_state_d;
    logic            r_last_q, w_last_d;
    logic [TO_W-1:0] r_cnt_q, w_cnt_d;
    logic            r_addr_hi_q, w_addr_hi_d;
    logic [1:0]      r_bus_grant_q, w_bus_grant_d;
    logic [2:0]      r_slave_grant_q, w_slave_grant_d;
    logic            r_m1_ack_q, w_m1_ack_d;
    logic            r_m2_ack_q, w_m2_ack_d;
    logic            r_addr_err_q, w_addr_err_d;
    logic            r_timeout_q, w_timeout_d;

    logic            w_req;
    logic            w_addr;
    logic            w_addr_valid;
    logic [TO_W-1:0] w_cnt_inc;
    logic            w_expired;

    // Only the granted master's lines are observed once the bus is owned.
    assign w_req        = r_bus_grant_q[1] ? m2_req        : m1_req;
    assign w_addr       = r_bus_grant_q[1] ? m2_addr       : m1_addr;
    assign w_addr_valid = r_bus_grant_q[1] ? m2_addr_valid : m1_addr_valid;

    assign w_cnt_inc = (r_cnt_q == c_CNT_MAX) ? r_cnt_q : r_cnt_q + TO_W'(1);
    assign w_expired = (w_cnt_inc >= c_TIMEOUT);

    always_comb begin
        w_state_d       = r_state_q;
        w_last_d        = r_last_q;
        w_cnt_d         = r_cnt_q;
        w_addr_hi_d     = r_addr_hi_q;
        w_bus_grant_d   = r_bus_grant_q;
        w_slave_grant_d = r_slave_grant_q;
        w_m1_ack_d      = 1'b0;
        w_m2_ack_d      = 1'b0;
        w_addr_err_d    = 1'b0;
        w_timeout_d     = 1'b0;

        case (r_state_q)
            c_IDLE: begin
                // r_last_q set means master 2 owned the bus most recently.
                if (m1_req && (!m2_req || r_last_q)) begin
                    w_bus_grant_d = 2'b01;
                    w_last_d      = 1'b0;
                    w_cnt_d       = '0;
                    w_state_d     = c_GRANT;
                end else if (m2_req) begin
                    w_bus_grant_d = 2'b10;
                    w_last_d      = 1'b1;
                    w_cnt_d       = '0;
                    w_state_d     = c_GRANT;
                end
            end
            c_GRANT: begin
                w_cnt_d = w_cnt_inc;
                if (w_expired) begin
                    w_timeout_d = 1'b1;
                    w_state_d   = c_RELEASE;
                end else if (!w_req) begin
                    w_state_d = c_RELEASE;
                end else if (w_addr_valid) begin
                    w_addr_hi_d = w_addr;
                    w_state_d   = c_ADDR;
                end
            end
            c_ADDR: begin
                w_cnt_d = w_cnt_inc;
                if (w_expired) begin
                    w_timeout_d = 1'b1;
                    w_state_d   = c_RELEASE;
                end else if (!w_req) begin
                    w_state_d = c_RELEASE;
                end else if (w_addr_valid) begin
                    if ({r_addr_hi_q, w_addr} == 2'b00) begin
                        w_addr_err_d = 1'b1;
                        w_state_d    = c_RELEASE;
                    end else begin
                        w_slave_grant_d = {r_addr_hi_q, w_addr, 1'b1};
                        w_m1_ack_d      = r_bus_grant_q[0];
                        w_m2_ack_d      = r_bus_grant_q[1];
                        w_state_d       = c_CONNECT;
                    end
                end
            end
            c_CONNECT: begin
                w_cnt_d = w_cnt_inc;
                if (w_expired) begin
                    w_timeout_d = 1'b1;
                    w_state_d   = c_RELEASE;
                end else if (!w_req) begin
                    w_state_d = c_RELEASE;
                end
            end
            c_RELEASE: begin
                w_state_d = c_IDLE;
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase

        // RELEASE is only ever entered from an owning state, so clear here once.
        if (w_state_d == c_RELEASE) begin
            w_bus_grant_d   = 2'b00;
            w_slave_grant_d = 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= c_IDLE;
            r_last_q        <= 1'b1;
            r_cnt_q         <= '0;
            r_addr_hi_q     <= 1'b0;
            r_bus_grant_q   <= 2'b00;
            r_slave_grant_q <= 3'b000;
            r_m1_ack_q      <= 1'b0;
            r_m2_ack_q      <= 1'b0;
            r_addr_err_q    <= 1'b0;
            r_timeout_q     <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_last_q        <= w_last_d;
            r_cnt_q         <= w_cnt_d;
            r_addr_hi_q     <= w_addr_hi_d;
            r_bus_grant_q   <= w_bus_grant_d;
            r_slave_grant_q <= w_slave_grant_d;
            r_m1_ack_q      <= w_m1_ack_d;
            r_m2_ack_q      <= w_m2_ack_d;
            r_addr_err_q    <= w_addr_err_d;
            r_timeout_q     <= w_timeout_d;
        end
    end

    assign bus_grant   = r_bus_grant_q;
    assign slave_grant = r_slave_grant_q;
    assign m1_ack      = r_m1_ack_q;
    assign m2_ack      = r_m2_ack_q;
    assign addr_err    = r_addr_err_q;
    assign timeout     = r_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Vector-table and scoreboard bench for bus_arbiter (TIMEOUT=10).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m1_req = 1'b0, m1_addr = 1'b0, m1_addr_valid = 1'b0;
    logic       m2_req = 1'b0, m2_addr = 1'b0, m2_addr_valid = 1'b0;
    logic [1:0] bus_grant;
    logic [2:0] slave_grant;
    logic       m1_ack, m2_ack, addr_err, timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT(10), .TO_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .m1_req       (m1_req),
        .m1_addr      (m1_addr),
        .m1_addr_valid(m1_addr_valid),
        .m2_req       (m2_req),
        .m2_addr      (m2_addr),
        .m2_addr_valid(m2_addr_valid),
        .bus_grant    (bus_grant),
        .slave_grant  (slave_grant),
        .m1_ack       (m1_ack),
        .m2_ack       (m2_ack),
        .addr_err     (addr_err),
        .timeout      (timeout)
    );

    // in   = {m1_req, m1_addr, m1_addr_valid, m2_req, m2_addr, m2_addr_valid}
    // expv = {bus_grant, slave_grant, m1_ack, m2_ack, addr_err, timeout} after the edge
    typedef struct {
        logic       rst;
        logic [5:0] in;
        logic [8:0] expv;
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] exp_q[$];
    string      name_q[$];

    task automatic add(input string n, input logic r, input logic [5:0] i,
                       input logic [1:0] bg, input logic [2:0] sg, input logic [3:0] p);
        vec_t v;
        v.rst  = r;
        v.in   = i;
        v.expv = {bg, sg, p};
        v.name = n;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic ok, input logic [8:0] got, input logic [8:0] want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %b required %b", n, got, want);
        end
    endtask

    function automatic logic [8:0] outs();
        return {bus_grant, slave_grant, m1_ack, m2_ack, addr_err, timeout};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         waited;
        logic [8:0] e;
        string      n;

        add("reset0", 1, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        add("reset1", 1, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        // single master, slave 2
        add("s_grant", 0, 6'b100_000, 2'b01, 3'b000, 4'b0000);
        add("s_bit1",  0, 6'b111_000, 2'b01, 3'b000, 4'b0000);
        add("s_bit0",  0, 6'b101_000, 2'b01, 3'b101, 4'b1000);
        for (int k = 0; k < 3; k++) add("s_hold", 0, 6'b100_000, 2'b01, 3'b101, 4'b0000);
        add("s_drop",  0, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        add("s_idle",  0, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        // round robin from reset
        add("rr_rst",     1, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        add("rr_m1",      0, 6'b100_100, 2'b01, 3'b000, 4'b0000);
        add("rr_m1b1",    0, 6'b111_100, 2'b01, 3'b000, 4'b0000);
        add("rr_m1b0",    0, 6'b111_100, 2'b01, 3'b111, 4'b1000);
        add("rr_m1rel",   0, 6'b000_100, 2'b00, 3'b000, 4'b0000);
        add("rr_relx",    0, 6'b100_100, 2'b00, 3'b000, 4'b0000);
        add("rr_m2",      0, 6'b100_100, 2'b10, 3'b000, 4'b0000);
        add("rr_m2b1",    0, 6'b100_101, 2'b10, 3'b000, 4'b0000);
        add("rr_m2b0",    0, 6'b100_111, 2'b10, 3'b011, 4'b0100);
        add("rr_m2rel",   0, 6'b100_000, 2'b00, 3'b000, 4'b0000);
        add("rr_idle",    0, 6'b100_100, 2'b00, 3'b000, 4'b0000);
        add("rr_m1again", 0, 6'b100_100, 2'b01, 3'b000, 4'b0000);
        add("gr_abort",   0, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        add("gr_idle",    0, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        // address 00 from master 2, with a gap between bits
        add("e_m2",   0, 6'b000_100, 2'b10, 3'b000, 4'b0000);
        add("e_b1",   0, 6'b000_101, 2'b10, 3'b000, 4'b0000);
        add("e_gap",  0, 6'b000_100, 2'b10, 3'b000, 4'b0000);
        add("e_b0",   0, 6'b000_101, 2'b00, 3'b000, 4'b0010);
        add("e_idle", 0, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        // req drop in ADDR
        add("a_m1",   0, 6'b100_000, 2'b01, 3'b000, 4'b0000);
        add("a_b1",   0, 6'b111_000, 2'b01, 3'b000, 4'b0000);
        add("a_drop", 0, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        add("a_idle", 0, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        // timeout with no address: release 10 cycles after grant
        add("to_grant", 0, 6'b100_000, 2'b01, 3'b000, 4'b0000);
        for (int k = 0; k < 9; k++) add("to_wait", 0, 6'b100_000, 2'b01, 3'b000, 4'b0000);
        add("to_fire",  0, 6'b100_000, 2'b00, 3'b000, 4'b0001);
        add("to_rel",   0, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        add("to_idle",  0, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        // timeout wins over address completion in the same cycle
        add("tp_grant", 0, 6'b100_000, 2'b01, 3'b000, 4'b0000);
        for (int k = 0; k < 8; k++) add("tp_wait", 0, 6'b100_000, 2'b01, 3'b000, 4'b0000);
        add("tp_b1",    0, 6'b111_000, 2'b01, 3'b000, 4'b0000);
        add("tp_b0",    0, 6'b111_000, 2'b00, 3'b000, 4'b0001);
        add("tp_rel",   0, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        add("tp_idle",  0, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        // reset during CONNECT to slave 3
        add("rc_m2",    0, 6'b000_100, 2'b10, 3'b000, 4'b0000);
        add("rc_b1",    0, 6'b000_111, 2'b10, 3'b000, 4'b0000);
        add("rc_b0",    0, 6'b000_111, 2'b10, 3'b111, 4'b0100);
        add("rc_hold",  0, 6'b000_100, 2'b10, 3'b111, 4'b0000);
        add("rc_rst",   1, 6'b000_100, 2'b00, 3'b000, 4'b0000);
        add("rc_regr",  0, 6'b000_100, 2'b10, 3'b000, 4'b0000);
        add("rc_drop",  0, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        add("rc_idle",  0, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        // gap in master 1 address while master 2 valid toggles
        add("gp_m1",    0, 6'b100_000, 2'b01, 3'b000, 4'b0000);
        add("gp_b1",    0, 6'b111_001, 2'b01, 3'b000, 4'b0000);
        add("gp_gap0",  0, 6'b100_000, 2'b01, 3'b000, 4'b0000);
        add("gp_gap1",  0, 6'b100_011, 2'b01, 3'b000, 4'b0000);
        add("gp_gap2",  0, 6'b100_001, 2'b01, 3'b000, 4'b0000);
        add("gp_b0",    0, 6'b111_000, 2'b01, 3'b111, 4'b1000);
        add("gp_hold",  0, 6'b100_011, 2'b01, 3'b111, 4'b0000);
        add("gp_drop",  0, 6'b000_000, 2'b00, 3'b000, 4'b0000);
        add("gp_idle",  0, 6'b000_000, 2'b00, 3'b000, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            {m1_req, m1_addr, m1_addr_valid, m2_req, m2_addr, m2_addr_valid} = vecs[i].in;
            exp_q.push_back(vecs[i].expv);
            name_q.push_back($sformatf("%s[%0d]", vecs[i].name, i));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, outs() === e, outs(), e);
        end

        // master 2 alone after master 1 last owned the bus: slave 2
        @(negedge clk);
        m2_req = 1'b1;
        waited = 0;
        while (bus_grant !== 2'b10 && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("hs_grant_latency", (bus_grant === 2'b10) && (waited == 1),
              {7'd0, bus_grant}, 9'b000000010);
        @(negedge clk);
        m2_addr = 1'b1; m2_addr_valid = 1'b1;
        @(negedge clk);
        m2_addr = 1'b0;
        @(posedge clk);
        #1;
        check("hs_connect", outs() === 9'b10_101_0100, outs(), 9'b10_101_0100);
        @(negedge clk);
        m2_addr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("hs_ack_width", outs() === 9'b10_101_0000, outs(), 9'b10_101_0000);
        @(negedge clk);
        m2_req = 1'b0;
        @(posedge clk);
        #1;
        check("hs_release", outs() === 9'b0, outs(), 9'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
